fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's show-ahead FIFOs (`empty`/`rd_en` port, head data valid while not empty). It pops words from the FIFO into a 2-entry output buffer and presents them on a valid/ready stream. It frames the stream into packets of programmable length with a last flag. There is no combinational path from `m_ready_i` to `fifo_rd_en_o`, so the block also acts as the timing break between FIFO and consumer.

---
 rtl/fifo_stream_reader.sv | 52 +++++
 tb/tb_fifo_stream_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead FIFO through a 2-entry buffer onto a framed valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_rd_en_o,
  input  logic [LEN_W-1:0] pkt_len_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic             busy_o
);
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic [LEN_W-1:0] beat_q, beat_d, len_q, len_d;
  logic             pop, out_free;
  // Read enable looks only at buffer occupancy, keeping m_ready_i off the FIFO pop path.
  always_comb begin
    fifo_rd_en_o = rst_ni && !fifo_empty_i && (cnt_q < 2'd2);
    m_valid_o    = cnt_q != 2'd0;
    m_last_o     = m_valid_o && (beat_q == len_q);
    m_data_o     = out_q;
    busy_o       = (beat_q != '0) || (cnt_q != 2'd0);
    pop          = m_valid_o && m_ready_i;
    out_free     = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop);
    cnt_d        = cnt_q + 2'(fifo_rd_en_o) - 2'(pop);
    out_d        = (pop && cnt_q == 2'd2) ? skid_q : (fifo_rd_en_o && out_free) ? fifo_data_i : out_q;
    skid_d       = (fifo_rd_en_o && !out_free) ? fifo_data_i : skid_q;
    beat_d       = pop ? (m_last_o ? '0 : beat_q + LEN_W'(1)) : beat_q;
    len_d        = ((beat_q == '0 && !m_valid_o) || (pop && m_last_o)) ? pkt_len_i : len_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      out_q  <= '0;
      skid_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      skid_q <= skid_d;
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: vector table, directed corner sequences and randomized scoreboard run.
module tb_fifo_stream_reader;
  logic       clk_i, rst_ni, fifo_empty_i, fifo_rd_en_o, m_valid_o, m_ready_i, m_last_o, busy_o;
  logic [7:0] fifo_data_i, pkt_len_i, m_data_o;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       empty;
    logic [7:0] data;
    logic       ready;
    logic [7:0] len;
    logic       rd, v;
    logic [7:0] d;
    logic       l, b;
  } vec_t;
  vec_t tbl[11];

  fifo_stream_reader #(.WIDTH(8), .LEN_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_en_o(fifo_rd_en_o), .pkt_len_i(pkt_len_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_last_o(m_last_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = fifo_q.size() == 0;
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // The bench FIFO pops its head whenever the DUT strobed rd_en before the edge.
  task automatic tick();
    logic rd;
    #1;
    rd = fifo_rd_en_o;
    @(posedge clk_i);
    #1;
    if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  initial begin
    int k, k2, rd_pulses, len_l, cyc;
    int lens[3];
    logic       prev_stall, prev_l;
    logic [7:0] prev_d, w;
    lens = '{0, 4, 7};
    tbl[0]  = '{1'b0, 8'hA1, 1'b1, 8'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'hB2, 1'b1, 8'd2, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'hC3, 1'b1, 8'd2, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'hC3, 1'b1, 8'd2, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 8'hC3, 1'b1, 8'd2, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h11, 1'b1, 8'd0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h22, 1'b1, 8'd0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h33, 1'b1, 8'd0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h44, 1'b1, 8'd0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'h44, 1'b1, 8'd0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 8'h44, 1'b1, 8'd0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0};

    rst_ni = 1'b1; fifo_empty_i = 1'b0; fifo_data_i = 8'hAA; m_ready_i = 1'b1; pkt_len_i = 8'd2;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en_o), 0);
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_last", 32'(m_last_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_data", 32'(m_data_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    foreach (tbl[i]) begin
      fifo_empty_i = tbl[i].empty; fifo_data_i = tbl[i].data;
      m_ready_i = tbl[i].ready; pkt_len_i = tbl[i].len;
      #1;
      chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en_o), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid_o), 32'(tbl[i].v));
      chk($sformatf("vec%0d_data", i), 32'(m_data_o), 32'(tbl[i].d));
      chk($sformatf("vec%0d_last", i), 32'(m_last_o), 32'(tbl[i].l));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tbl[i].b));
      @(posedge clk_i);
      #1;
    end
    drive_fifo();

    // Stall: buffer fills to two words then stops reading until the consumer frees it.
    pkt_len_i = 8'd5; m_ready_i = 1'b0; rd_pulses = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h60 + i));
    drive_fifo();
    for (int c = 0; c < 4; c++) begin
      #1;
      if (fifo_rd_en_o) rd_pulses++;
      if (c >= 1) begin
        chk("stall_valid", 32'(m_valid_o), 1);
        chk("stall_data", 32'(m_data_o), 32'h60);
      end
      tick();
    end
    chk("stall_rd_pulses", 32'(rd_pulses), 2);
    m_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("release_valid", 32'(m_valid_o), 1);
      chk("release_data", 32'(m_data_o), 32'(8'h60 + c));
      chk("release_last", 32'(m_last_o), 32'(c == 5));
      tick();
    end
    #1 chk("release_idle_busy", 32'(busy_o), 0);

    // Length change mid-packet only affects the following packet.
    pkt_len_i = 8'd3; k = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h70 + i));
    drive_fifo();
    for (cyc = 0; cyc < 30 && k < 6; cyc++) begin
      #1;
      if (m_valid_o && m_ready_i) begin
        chk("lenchg_data", 32'(m_data_o), 32'(8'h70 + k));
        chk("lenchg_last", 32'(m_last_o), 32'(k >= 3));
        k++;
        if (k == 2) pkt_len_i = 8'd0;
      end
      tick();
    end
    chk("lenchg_count", 32'(k), 6);
    #1 chk("lenchg_idle_busy", 32'(busy_o), 0);

    for (int r = 0; r < 3; r++) begin
      pkt_len_i = 8'(lens[r]); len_l = lens[r] + 1;
      k = 0; k2 = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0; exp_q.delete();
      for (cyc = 0; cyc < 4000 && k < 200; cyc++) begin
        m_ready_i = $urandom_range(0, 99) < 60;
        if (k2 < 200 && $urandom_range(0, 99) < 55) begin
          w = 8'($urandom);
          fifo_q.push_back(w); exp_q.push_back(w); k2++;
        end
        drive_fifo();
        #1;
        chk("rand_rd_while_empty", 32'(fifo_rd_en_o && fifo_empty_i), 0);
        if (prev_stall) begin
          chk("rand_hold_valid", 32'(m_valid_o), 1);
          chk("rand_hold_data", 32'(m_data_o), 32'(prev_d));
          chk("rand_hold_last", 32'(m_last_o), 32'(prev_l));
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) chk("rand_extra_beat", 1, 0);
          else chk("rand_data", 32'(m_data_o), 32'(exp_q.pop_front()));
          chk("rand_last", 32'(m_last_o), 32'((k % len_l) == len_l - 1));
          k++;
        end
        prev_stall = m_valid_o && !m_ready_i; prev_d = m_data_o; prev_l = m_last_o;
        tick();
      end
      chk("rand_count", 32'(k), 200);
      #1 chk("rand_idle_busy", 32'(busy_o), 0);
    end

    // Asynchronous reset while beat 2 of a 4-beat packet sits with both buffer entries full.
    pkt_len_i = 8'd3; m_ready_i = 1'b1; k = 0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h80 + i));
    drive_fifo();
    for (cyc = 0; cyc < 20 && k < 2; cyc++) begin
      #1;
      if (m_valid_o && m_ready_i) k++;
      tick();
    end
    chk("rstmid_pre_count", 32'(k), 2);
    m_ready_i = 1'b0;
    tick(); tick();
    #1;
    chk("rstmid_pre_valid", 32'(m_valid_o), 1);
    chk("rstmid_pre_busy", 32'(busy_o), 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rstmid_valid", 32'(m_valid_o), 0);
    chk("rstmid_rd_en", 32'(fifo_rd_en_o), 0);
    chk("rstmid_busy", 32'(busy_o), 0);
    tick();
    rst_ni = 1'b1; m_ready_i = 1'b1; pkt_len_i = 8'd1;
    fifo_q.delete(); fifo_q.push_back(8'h91); fifo_q.push_back(8'h92);
    drive_fifo();
    k2 = 0;
    for (cyc = 0; cyc < 10 && k2 < 2; cyc++) begin
      #1;
      if (m_valid_o && m_ready_i) begin
        chk("post_rst_data", 32'(m_data_o), 32'(8'h91 + k2));
        chk("post_rst_last", 32'(m_last_o), 32'(k2 == 1));
        k2++;
      end
      tick();
    end
    chk("post_rst_count", 32'(k2), 2);
    #1 chk("post_rst_busy", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
